// File: rtl/add_h_border_pkg.sv
// rtl/add_h_border_pkg.sv - shared types and constants for the horizontal border inserter
// Purpose: per-flux state encoding, payload widths, default border width and
//          the tag-width helper used by add_h_border and its sub-modules.
package add_h_border_pkg;

  localparam int DATA_WIDTH_IN_OUT = 18;
  localparam int DATA_WIDTH_EXT    = 7;
  localparam int PAD_W_DEFAULT     = 7;

  // RPAD is only reachable when ADD_H_RIGHT_PAD_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAD  = 2'd1,
    ST_WORK = 2'd2,
    ST_RPAD = 2'd3
  } state_e;

  // A single flux still needs one tag bit so port widths stay non-zero.
  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/add_h_border_arbiter.sv
// rtl/add_h_border_arbiter.sv - lowest-index-first flux arbiter
// Purpose: picks the lowest eligible flux each cycle.
// Ports:   elig_i  per-flux eligibility vector
//          tag_o   index of the winning flux (zero when none)
//          valid_o at least one flux is eligible
module add_h_arbiter #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      elig_i,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 valid_o
);

  // Scan downwards so the lowest eligible index is the last one assigned.
  always_comb begin
    tag_o   = '0;
    valid_o = 1'b0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        tag_o   = TAG_WIDTH'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_dual_ported.sv
// rtl/ram_dual_ported.sv - small context RAM, combinational read, synchronous write
// Purpose: per-flux counter storage addressed by flux tag.
// Ports:   clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
// Contents are not initialised by any reset; the owner writes before reading.
module ram_dual_ported #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 7,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/add_h_border.sv
// rtl/add_h_border.sv - multi-flux horizontal border inserter for the pixel path
// Purpose: per flux, pops a frame size M, then emits M rows of M pixels, each row
//          starting with its first input pixel repeated PAD_W extra times.
//          Fluxes share tagged FIFOs; one transaction per cycle, lowest flux first.
// Ports:   clk, rst (asynchronous, active-high)
//          read_port_in_pel_*   pixel FIFO (first-word-fall-through, per-flux empty/read)
//          read_port_ext_size_* frame size FIFO (per-flux empty/read)
//          write_port_out_pel_* padded pixel output (per-flux full, single write)
// Option:  ADD_H_RIGHT_PAD_EN also replicates the last pixel of each row PAD_W times.
module add_h_border
  import add_h_border_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int PAD_W     = PAD_W_DEFAULT,
  parameter int TAG_WIDTH = tag_width(FLUX)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH_IN_OUT+TAG_WIDTH-1:0] read_port_in_pel_dout_i,
  input  logic [FLUX-1:0]                        read_port_in_pel_empty_i,
  output logic [FLUX-1:0]                        read_port_in_pel_read_o,
  input  logic [DATA_WIDTH_EXT+TAG_WIDTH-1:0]    read_port_ext_size_dout_i,
  input  logic [FLUX-1:0]                        read_port_ext_size_empty_i,
  output logic [FLUX-1:0]                        read_port_ext_size_read_o,
  output logic [DATA_WIDTH_IN_OUT+TAG_WIDTH-1:0] write_port_out_pel_din_o,
  input  logic [FLUX-1:0]                        write_port_out_pel_full_i,
  output logic                                   write_port_out_pel_write_o
);

  localparam int EW  = DATA_WIDTH_EXT;
  localparam int EW1 = DATA_WIDTH_EXT + 1;

  localparam logic [EW-1:0] PAD_LAST = EW'(PAD_W - 1);
`ifdef ADD_H_RIGHT_PAD_EN
  localparam logic [EW-1:0] PAD_LEN  = EW'(PAD_W);
  // Frames must be wider than both borders, otherwise they are dropped.
  localparam logic [EW:0]   MIN_EXCL = EW1'(2 * PAD_W);
`else
  localparam logic [EW:0]   MIN_EXCL = EW1'(PAD_W);
`endif

  state_e                 state_q [FLUX];
  state_e                 state_d;
  state_e                 cur_state;

  logic [FLUX-1:0]        elig;
  logic [TAG_WIDTH-1:0]   arb_tag;
  logic                   arb_valid;
  logic                   act;

  logic [EW-1:0]          max_q, cnt_h_q, cnt_v_q;
  logic [EW-1:0]          max_d, cnt_h_d, cnt_v_d;
  logic [EW-1:0]          max_last;
  logic [EW-1:0]          ext_m;
  logic [DATA_WIDTH_IN_OUT-1:0] pix;

  logic                   pop_ext, pop_pel, wr;

  assign ext_m = read_port_ext_size_dout_i[EW-1:0];
  assign pix   = read_port_in_pel_dout_i[DATA_WIDTH_IN_OUT-1:0];

  // An idle flux waits for a frame size; an active flux needs a pixel and room.
  always_comb begin
    elig = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (state_q[i] == ST_IDLE) begin
        elig[i] = ~read_port_ext_size_empty_i[i];
      end else begin
        elig[i] = ~read_port_in_pel_empty_i[i] & ~write_port_out_pel_full_i[i];
      end
    end
  end

  add_h_arbiter #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_arb (
    .elig_i  (elig),
    .tag_o   (arb_tag),
    .valid_o (arb_valid)
  );

  // No transaction at all while reset is held, even if FIFOs report data.
  assign act       = arb_valid & ~rst;
  assign cur_state = state_q[arb_tag];
  assign max_last  = max_q - 1'b1;

  // Every transaction rewrites the winner's whole context, so the RAM write
  // enable is simply the transaction strobe; losers are never touched.
  ram_dual_ported #(.DEPTH(FLUX), .WIDTH(EW), .AW(TAG_WIDTH)) u_ram_max (
    .clk(clk), .we_i(act), .waddr_i(arb_tag), .wdata_i(max_d),
    .raddr_i(arb_tag), .rdata_o(max_q)
  );

  ram_dual_ported #(.DEPTH(FLUX), .WIDTH(EW), .AW(TAG_WIDTH)) u_ram_cnt_h (
    .clk(clk), .we_i(act), .waddr_i(arb_tag), .wdata_i(cnt_h_d),
    .raddr_i(arb_tag), .rdata_o(cnt_h_q)
  );

  ram_dual_ported #(.DEPTH(FLUX), .WIDTH(EW), .AW(TAG_WIDTH)) u_ram_cnt_v (
    .clk(clk), .we_i(act), .waddr_i(arb_tag), .wdata_i(cnt_v_d),
    .raddr_i(arb_tag), .rdata_o(cnt_v_q)
  );

  always_comb begin
    state_d = cur_state;
    max_d   = max_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    pop_ext = 1'b0;
    pop_pel = 1'b0;
    wr      = 1'b0;
    if (act) begin
      unique case (cur_state)
        ST_IDLE: begin
          pop_ext = 1'b1;
          max_d   = ext_m;
          cnt_h_d = '0;
          cnt_v_d = '0;
          if ({1'b0, ext_m} > MIN_EXCL) begin
            state_d = ST_PAD;
          end
        end
        ST_PAD: begin
          // Head pixel is replicated without being consumed.
          wr      = 1'b1;
          cnt_h_d = cnt_h_q + 1'b1;
          if (cnt_h_q == PAD_LAST) begin
            state_d = ST_WORK;
          end
        end
        ST_WORK: begin
          wr      = 1'b1;
          cnt_h_d = cnt_h_q + 1'b1;
`ifdef ADD_H_RIGHT_PAD_EN
          // Last real pixel of the row stays at the head for the right border.
          if (cnt_h_q == max_q - PAD_LEN - 1'b1) begin
            state_d = ST_RPAD;
          end else begin
            pop_pel = 1'b1;
          end
`else
          pop_pel = 1'b1;
          if (cnt_h_q == max_last) begin
            cnt_h_d = '0;
            if (cnt_v_q == max_last) begin
              cnt_v_d = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_v_d = cnt_v_q + 1'b1;
              state_d = ST_PAD;
            end
          end
`endif
        end
        ST_RPAD: begin
`ifdef ADD_H_RIGHT_PAD_EN
          wr      = 1'b1;
          cnt_h_d = cnt_h_q + 1'b1;
          if (cnt_h_q == max_last) begin
            pop_pel = 1'b1;
            cnt_h_d = '0;
            if (cnt_v_q == max_last) begin
              cnt_v_d = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_v_d = cnt_v_q + 1'b1;
              state_d = ST_PAD;
            end
          end
`else
          state_d = ST_IDLE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else if (act) begin
      state_q[arb_tag] <= state_d;
    end
  end

  assign read_port_ext_size_read_o  = pop_ext ? (FLUX'(1) << arb_tag) : '0;
  assign read_port_in_pel_read_o    = pop_pel ? (FLUX'(1) << arb_tag) : '0;
  assign write_port_out_pel_write_o = wr;
  assign write_port_out_pel_din_o   = wr ? {arb_tag, pix} : 'x;

endmodule

// File: tb/tb_add_h_border.sv
// tb/tb_add_h_border.sv - directed self-checking bench for add_h_border
module tb_add_h_border;
  import add_h_border_pkg::*;

  localparam int PW = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] in_dout;
  logic [1:0]  in_empty, in_read;
  logic [7:0]  ext_dout;
  logic [1:0]  ext_empty, ext_read;
  logic [18:0] out_din;
  logic [1:0]  out_full;
  logic        out_write;

  always #5 clk = ~clk;

  add_h_border #(.FLUX(2), .PAD_W(PW)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .read_port_in_pel_dout_i    (in_dout),
    .read_port_in_pel_empty_i   (in_empty),
    .read_port_in_pel_read_o    (in_read),
    .read_port_ext_size_dout_i  (ext_dout),
    .read_port_ext_size_empty_i (ext_empty),
    .read_port_ext_size_read_o  (ext_read),
    .write_port_out_pel_din_o   (out_din),
    .write_port_out_pel_full_i  (out_full),
    .write_port_out_pel_write_o (out_write)
  );

  logic [17:0] pq    [2][$];
  logic [6:0]  eq    [2][$];
  logic [17:0] exp_q [2][$];
  logic [17:0] got_q [2][$];
  logic [17:0] hd_pel [2];
  logic [6:0]  hd_ext [2];

  int n_vec = 0;
  int n_err = 0;
  int n_pop [2];
  int cyc = 0;
  int stall_viol = 0;
  int first_wr [2];
  int last_wr [2];
  bit toggle_en = 1'b0;

  // Shared FIFO face: the head shown is that of the flux being served;
  // the tag bits are set to 1 to show they are ignored.
  assign in_dout  = {1'b1, hd_pel[dut.arb_tag]};
  assign ext_dout = {1'b1, hd_ext[dut.arb_tag]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int f = 0; f < 2; f++) begin
      in_empty[f]  = (pq[f].size() == 0);
      hd_pel[f]    = in_empty[f] ? 18'd0 : pq[f][0];
      ext_empty[f] = (eq[f].size() == 0);
      hd_ext[f]    = ext_empty[f] ? 7'd0 : eq[f][0];
    end
  endtask

  task automatic cycle();
    logic [1:0]  rd, er, fl;
    logic        wr;
    logic [18:0] dv;
    @(negedge clk);
    rd = in_read; er = ext_read; wr = out_write; dv = out_din; fl = out_full;
    @(posedge clk);
    #1;
    cyc++;
    if (wr) begin
      if (fl[dv[18]]) stall_viol++;
      got_q[dv[18]].push_back(dv[17:0]);
      if (first_wr[dv[18]] < 0) first_wr[dv[18]] = cyc;
      last_wr[dv[18]] = cyc;
    end
    for (int f = 0; f < 2; f++) begin
      if (rd[f]) begin
        if (pq[f].size() > 0) pq[f].delete(0); else stall_viol++;
        n_pop[f]++;
      end
      if (er[f]) begin
        if (eq[f].size() > 0) eq[f].delete(0); else stall_viol++;
      end
    end
    refresh();
    if (toggle_en) out_full[0] = ((cyc / 3) % 2) == 1;
  endtask

  // Queues a frame of size m for flux f with pixels base+1, base+2, ...
  // and the rows the block must produce from them.
  task automatic push_frame(input int f, input int m, input int base);
    int k;
    int p0;
`ifdef ADD_H_RIGHT_PAD_EN
    k = m - 2 * PW;
`else
    k = m - PW;
`endif
    eq[f].push_back(7'(m));
    if (k > 0) begin
      for (int r = 0; r < m; r++) begin
        p0 = base + r * k + 1;
        for (int j = 0; j < k; j++) pq[f].push_back(18'(p0 + j));
        for (int c = 0; c <= PW; c++) exp_q[f].push_back(18'(p0));
        for (int j = 1; j < k; j++) exp_q[f].push_back(18'(p0 + j));
`ifdef ADD_H_RIGHT_PAD_EN
        for (int c = 0; c < PW; c++) exp_q[f].push_back(18'(p0 + k - 1));
`endif
      end
    end
    refresh();
  endtask

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(pq[0].size() == 0 && pq[1].size() == 0 && eq[0].size() == 0 &&
             eq[1].size() == 0 && got_q[0].size() >= exp_q[0].size() &&
             got_q[1].size() >= exp_q[1].size()) && n < budget) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 4; i++) cycle();
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic cmp_streams(input string tag);
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("%s_cnt%0d", tag, f), got_q[f].size(), exp_q[f].size());
      for (int i = 0; i < exp_q[f].size() && i < got_q[f].size(); i++)
        chk($sformatf("%s_f%0d_px%0d", tag, f, i), 32'(got_q[f][i]), 32'(exp_q[f][i]));
      got_q[f].delete();
      exp_q[f].delete();
      n_pop[f] = 0;
      first_wr[f] = -1;
      last_wr[f] = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    out_full = 2'b00;
    for (int f = 0; f < 2; f++) begin
      n_pop[f] = 0; first_wr[f] = -1; last_wr[f] = -1;
    end
    refresh();
    repeat (2) @(posedge clk);
    #1;
`ifndef ADD_H_RIGHT_PAD_EN
    // Reset state with a frame size already waiting.
    push_frame(0, 10, 0);
    @(negedge clk);
    chk("rst_ext_read", 32'(ext_read), 32'd0);
    chk("rst_in_read", 32'(in_read), 32'd0);
    chk("rst_write", 32'(out_write), 32'd0);
    chk("rst_state", 32'(dut.state_q[0]), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single flux, M=10, pixels 1..30.
    run_done("t1", 400);
    chk("t1_pops", n_pop[0], 30);
    chk("t1_idle", 32'(dut.state_q[0]), 32'(ST_IDLE));
    cmp_streams("t1");

    // Both fluxes M=8; flux0 must finish before flux1 writes anything.
    push_frame(0, 8, 'h100);
    push_frame(1, 8, 'h200);
    run_done("t2", 400);
    chk("t2_pops0", n_pop[0], 8);
    chk("t2_pops1", n_pop[1], 8);
    chk("t2_order", 32'(first_wr[1] > last_wr[0]), 32'd1);
    cmp_streams("t2");

    // Back-pressure on flux0 toggling every 3 cycles.
    push_frame(0, 10, 'h500);
    toggle_en = 1'b1;
    run_done("t3", 800);
    toggle_en = 1'b0;
    out_full = 2'b00;
    chk("t3_stall", stall_viol, 0);
    chk("t3_pops", n_pop[0], 30);
    cmp_streams("t3");

    // M=7 is dropped without pixel pops, then M=9 gives 81 outputs.
    push_frame(0, 7, 'h600);
    push_frame(0, 9, 'h700);
    run_done("t4", 400);
    chk("t4_pops", n_pop[0], 18);
    cmp_streams("t4");

    // Reset after 25 outputs of an M=10 frame, then a fresh M=8 frame.
    push_frame(0, 10, 'h800);
    for (int i = 0; i < 200 && got_q[0].size() < 25; i++) cycle();
    chk("t5_reach25", got_q[0].size(), 25);
    rst = 1'b1;
    pq[0].delete();
    got_q[0].delete();
    exp_q[0].delete();
    n_pop[0] = 0;
    push_frame(0, 8, 'h900);
    @(negedge clk);
    chk("t5_rst_write", 32'(out_write), 32'd0);
    chk("t5_rst_ext_read", 32'(ext_read), 32'd0);
    chk("t5_rst_in_read", 32'(in_read), 32'd0);
    chk("t5_rst_state", 32'(dut.state_q[0]), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_done("t5", 400);
    chk("t5_pops", n_pop[0], 8);
    cmp_streams("t5");
`else
    @(negedge clk);
    chk("rst_write", 32'(out_write), 32'd0);
    chk("rst_state", 32'(dut.state_q[0]), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // M=14 equals both borders and is dropped; M=16 gives 8xa, 8xb rows.
    push_frame(0, 14, 'hB00);
    push_frame(0, 16, 'hA00);
    run_done("rp", 800);
    chk("rp_pops", n_pop[0], 32);
    chk("rp_idle", 32'(dut.state_q[0]), 32'(ST_IDLE));
    cmp_streams("rp");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add_h_border.md
Name: add_h_border

Overview:
- Multi-flux horizontal border inserter for the HEVC Mulfwd pixel path, facing the border-removal stage.
- Per frame, per flux: pops one ext_size word M, then emits M rows of M pixels.
- Each row is built by replicating the row's first input pixel PAD_W extra times on the left, then passing the remaining input pixels.
- Fluxes are time-multiplexed on shared tagged FIFOs; one transaction is performed per cycle.

Parameters:
- FLUX, 2, number of interleaved data fluxes; TAG_WIDTH = $clog2(FLUX).
- PAD_W, 7, left border width in replicated pixels.
- DATA_WIDTH_IN_OUT, 18, pixel payload width.
- DATA_WIDTH_EXT, 7, ext_size payload width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- read_port_in_pel  read_interface.actor  dout 18+TAG_WIDTH, empty/read FLUX  input pixels, first-word-fall-through.
- read_port_ext_size  read_interface.actor  dout 7+TAG_WIDTH, empty/read FLUX  frame size M per flux.
- write_port_out_pel  write_interface.actor  din 18+TAG_WIDTH, full FLUX, write 1  padded pixels.

Behaviour:
- Per-flux context:
  - state is held in a flop array, reset asynchronously to IDLE.
  - max, cnt_h and cnt_v are held in ram_dual_ported instances (DEPTH=FLUX, WIDTH=7), with combinational read and synchronous write, addressed by tag.
  - The RAMs are not cleared by reset; IDLE initialises them.
- States: IDLE, PAD, WORK (2-bit encoding).
- Eligibility of flux i:
  - IDLE: ext_size.empty[i]==0.
  - PAD or WORK: in_pel.empty[i]==0 and out_pel.full[i]==0.
- Arbitration: the lowest eligible index wins. If none is eligible: no read, no write, no context change.
- IDLE:
  - Pop ext_size.
  - Write max=M, cnt_h=0, cnt_v=0.
  - If M>PAD_W, go to PAD; otherwise stay IDLE and emit nothing (frame discarded).
- PAD:
  - Write {tag, in_pel.dout} without popping; cnt_h++.
  - When cnt_h==PAD_W-1, go to WORK.
- WORK:
  - Write {tag, dout} and pop; cnt_h++.
  - If cnt_h==max-1 (row end): cnt_h=0.
    - If cnt_v==max-1: cnt_v=0, go to IDLE.
    - Else: cnt_v++, go to PAD.
- Per row: M-PAD_W pixels are consumed and M are produced. The first pixel appears PAD_W+1 times consecutively for that flux.
- Latency: combinational. write/read assert in the same cycle as eligibility; context updates at the next posedge.
- Output tag equals the winning flux index. Input tag bits are ignored; the payload is taken from the low 18 bits.
- Arithmetic: 7-bit unsigned compares. M up to 127; no wrap, since counters reset at row and frame end.
- Simultaneous eligibility: losers hold, with no state or RAM write.
- Back-pressure mid-row: the flux freezes with counters intact and resumes exactly where it stopped.
- Reset mid-frame: all states return to IDLE, the partial frame is abandoned, and FIFO contents are untouched.
- During reset and the idle cycle: read[*]=0, write=0, din=X.

Optional Feature:
- Macro: ADD_H_RIGHT_PAD_EN.
- Defined:
  - A fourth state RPAD is added.
  - In WORK, when cnt_h==max-1-PAD_W: write without popping and go to RPAD.
  - RPAD writes the head without popping PAD_W-1 times, then writes with pop on the last one.
  - Row end handling then happens from RPAD.
  - Per row, M-2·PAD_W pixels are consumed; the required M>2·PAD_W, otherwise the frame is discarded.
- Undefined: left border only, as described above.

Decomposition:
- Package add_h_border_pkg:
  - state enum (IDLE, PAD, WORK, RPAD).
  - DATA_WIDTH_IN_OUT, DATA_WIDTH_EXT, PAD_W default.
  - helper function for TAG_WIDTH.
- Sub-module add_h_arbiter: FLUX-wide eligibility vector in; tag plus valid out (lowest-index priority encoder).
- Counters and max reuse ram_dual_ported.

Test Plan:
- FLUX=2, flux0 ext=10, 30 pixels 1..30, no back-pressure -> 100 outputs tag 0; row r = eight copies of 3r+1, then 3r+2, 3r+3; exactly 30 pops; state returns to IDLE.
- Both fluxes ext=8, flux0 pixels 0x100+n, flux1 pixels 0x200+n -> flux0 always served while eligible; flux1 progresses only in flux0 gaps; each tag stream independently correct.
- Toggle out_pel.full[0] every 3 cycles during PAD and WORK -> no duplicated or lost pixel; output identical to the unstalled run.
- ext=7 (≤PAD_W), then ext=9 -> first frame yields zero writes and zero pixel pops; second frame yields 81 outputs.
- Assert rst for 1 cycle after 25 outputs of an ext=10 frame, then ext=8 -> no writes during reset; the next frame starts fresh at cnt_h=0 with 64 correct outputs.
- ADD_H_RIGHT_PAD_EN, ext=16, 2 pixels per row -> each row = 8×a, then 8×b; 2 pops per row.
